barrido_display: RTL and testbench

BARRIDO_DISPLAY -- requirements
Module: barrido_display

---
 rtl/barrido_display.sv | 153 +++++++++++++++
 tb/tb_barrido_display.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrido_display.sv
// rtl/barrido_display.sv - four-digit multiplexed BCD display scanner with shadow/active frame buffering
//
// Purpose:
//   Scans four BCD digits onto a shared 7-segment decoder, one digit slot
//   every DIV clocks. New values are written into a shadow register at any
//   time. They reach the displayed register only at a frame boundary, so a
//   frame never shows a mix of old and new digits.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous, active-high
//   carga     load strobe, dato sampled on every rising edge where carga=1
//   dato      four BCD digits, digit0 = dato[3:0] (rightmost)
//   nibble    code of the digit currently scanned (0 when blanked)
//   sel       index of the digit currently scanned, 0..3
//   habilita  one-hot digit enable (all zero when blanked)
//   blank     current digit is a suppressed leading zero
//   listo     one-cycle pulse after a new frame has been committed
//   invalido  registered flag, some displayed digit is above 9

module barrido_display #(
  parameter int unsigned DIV         = 50000,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        carga,
  input  logic [15:0] dato,
  output logic [3:0]  nibble,
  output logic [1:0]  sel,
  output logic [3:0]  habilita,
  output logic        blank,
  output logic        listo,
  output logic        invalido
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [15:0]   sombra;
  logic [15:0]   activo;
  logic          pendiente;
  logic          commit;
  logic [3:0]    digito;
  logic          ceros_arriba;
  logic          hay_invalido;

  // Prescaler: one tick per digit slot.
  assign tick = (cnt == CNT_MAX);

  // A frame boundary is the tick that wraps sel from 3 back to 0.
  assign commit = tick && (sel == 2'd3) && pendiente;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // sel is two bits wide, so 3 + 1 wraps to 0 on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel <= 2'd0;
    end else if (tick) begin
      sel <= sel + 2'd1;
    end
  end

  // Shadow register. A load on the commit edge wins over the clear of
  // pendiente: the old shadow is committed while the new value waits for
  // the next frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sombra    <= 16'h0000;
      pendiente <= 1'b0;
    end else begin
      if (carga) begin
        sombra <= dato;
      end
      if (carga) begin
        pendiente <= 1'b1;
      end else if (commit) begin
        pendiente <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      activo <= 16'h0000;
      listo  <= 1'b0;
    end else begin
      if (commit) begin
        activo <= sombra;
      end
      listo <= commit;
    end
  end

  // Codes A..F are still shown; they are only flagged here.
  always_comb begin
    hay_invalido = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (activo[4*i +: 4] > 4'd9) begin
        hay_invalido = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invalido <= 1'b0;
    end else begin
      invalido <= hay_invalido;
    end
  end

  // Digit select and leading-zero detection for the slot being scanned.
  // A digit k>0 is a leading zero when it and every digit to its left are 0.
  always_comb begin
    digito       = 4'h0;
    ceros_arriba = 1'b0;
    case (sel)
      2'd0: begin
        digito       = activo[3:0];
        ceros_arriba = 1'b0;
      end
      2'd1: begin
        digito       = activo[7:4];
        ceros_arriba = (activo[15:4] == 12'h000);
      end
      2'd2: begin
        digito       = activo[11:8];
        ceros_arriba = (activo[15:8] == 8'h00);
      end
      default: begin
        digito       = activo[15:12];
        ceros_arriba = (activo[15:12] == 4'h0);
      end
    endcase
  end

  assign blank    = BLANK_ZEROS ? ceros_arriba : 1'b0;
  assign nibble   = blank ? 4'h0 : digito;
  assign habilita = blank ? 4'b0000 : (4'b0001 << sel);

endmodule

// File: tb/tb_barrido_display.sv
// tb/tb_barrido_display.sv - self-checking bench for barrido_display against a time-based frame model

module tb_barrido_display;

  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        carga = 1'b0;
  logic [15:0] dato = 16'h0000;

  logic [3:0] nibble1, habilita1, nibble2, habilita2;
  logic [1:0] sel1, sel2;
  logic       blank1, listo1, invalido1, blank2, listo2, invalido2;

  int n_checks = 0;
  int n_fail = 0;

  barrido_display #(.DIV(DIV), .BLANK_ZEROS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .carga(carga), .dato(dato),
    .nibble(nibble1), .sel(sel1), .habilita(habilita1),
    .blank(blank1), .listo(listo1), .invalido(invalido1)
  );

  barrido_display #(.DIV(DIV), .BLANK_ZEROS(1'b0)) dut2 (
    .clk(clk), .reset(reset), .carga(carga), .dato(dato),
    .nibble(nibble2), .sel(sel2), .habilita(habilita2),
    .blank(blank2), .listo(listo2), .invalido(invalido2)
  );

  always #5 clk = ~clk;

  wire [12:0] obs1 = {sel1, nibble1, habilita1, blank1, listo1, invalido1};
  wire [12:0] obs2 = {sel2, nibble2, habilita2, blank2, listo2, invalido2};
  localparam logic [12:0] RESET_VEC = {2'd0, 4'h0, 4'b0001, 1'b0, 1'b0, 1'b0};

  // Reference model: time since reset release decides the scanned slot and
  // the frame boundaries; shadow/active buffering follows the load rules.
  int          m_t = 0;
  logic [15:0] m_sh = 16'h0;
  logic [15:0] m_ac = 16'h0;
  bit          m_pend = 1'b0;
  logic        m_listo = 1'b0;
  logic        m_inv = 1'b0;
  bit          m_boundary;

  function automatic logic inv16(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [12:0] exp_vec(input bit bz);
    int         k;
    logic [15:0] upper;
    logic [3:0] dig;
    logic       b;
    k     = (m_t / DIV) % 4;
    upper = m_ac >> (4 * k);
    dig   = 4'(upper & 16'hF);
    b     = bz && (k > 0) && (upper == 16'h0);
    return {2'(k), b ? 4'h0 : dig, b ? 4'h0 : 4'(1 << k), b, m_listo, m_inv};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_sh = 16'h0; m_ac = 16'h0; m_pend = 1'b0; m_listo = 1'b0; m_inv = 1'b0;
    end else begin
      m_boundary = (m_t % FRAME) == (FRAME - 1);
      m_inv = inv16(m_ac);
      m_listo = m_boundary && m_pend;
      if (m_listo) begin
        m_ac = m_sh;
        m_pend = 1'b0;
      end
      if (carga) begin
        m_sh = dato;
        m_pend = 1'b1;
      end
      m_t++;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs1 !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_state dut=%h required=%h", obs1, RESET_VEC);
    end
    n_checks++;
    if (obs2 !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_state_nb dut=%h required=%h", obs2, RESET_VEC);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    int pulses = 0;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL scan t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
      if (listo1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL scan_no_listo pulses=%0d required=0", pulses);
    end
  endtask

  task automatic test_load();
    int lat = -1;
    int pulses = 0;
    for (int c = 0; c < FRAME && ((m_t / DIV) % 4) != 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL load_align t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
    end
    carga = 1'b1; dato = 16'h1234;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      carga = 1'b0;
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL load t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
      if (listo1) begin
        pulses++;
        if (lat < 0) lat = c + 1;
      end
      if (pulses > 0 && !listo1) begin
        n_checks++;
        if (nibble1 !== 4'(4 - sel1) || habilita1 !== 4'(1 << sel1)) begin
          n_fail++; $display("FAIL load_digit sel=%0d nibble=%h habilita=%b required=%h", sel1, nibble1, habilita1, 4 - sel1);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || lat < 1 || lat > FRAME + 1) begin
      n_fail++; $display("FAIL load_listo pulses=%0d latency=%0d required 1 pulse within %0d", pulses, lat, FRAME + 1);
    end
  endtask

  task automatic test_blanking();
    carga = 1'b1; dato = 16'h0070;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      carga = 1'b0;
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL blank t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
      n_checks++;
      if (obs2 !== exp_vec(0)) begin
        n_fail++; $display("FAIL blank_off t=%0d dut=%h model=%h", m_t, obs2, exp_vec(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int c = 0; c < FRAME && (m_t % FRAME) != 5; c++) @(negedge clk);
    carga = 1'b1; dato = 16'h1111;
    @(negedge clk);
    carga = 1'b0;
    for (int c = 0; c < FRAME && (m_t % FRAME) != FRAME - 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL collide_pre t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
    end
    carga = 1'b1; dato = 16'h2222;
    for (int c = 0; c < 2 * FRAME + 2; c++) begin
      @(negedge clk);
      carga = 1'b0;
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL collide t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
      if (listo1) pulses++;
      if (c == 1) begin
        n_checks++;
        if (nibble1 !== 4'h1) begin
          n_fail++; $display("FAIL collide_first_frame nibble=%h required=1", nibble1);
        end
      end
      if (c == FRAME + 1) begin
        n_checks++;
        if (nibble1 !== 4'h2) begin
          n_fail++; $display("FAIL collide_second_frame nibble=%h required=2", nibble1);
        end
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL collide_listo pulses=%0d required=2", pulses);
    end
  endtask

  task automatic test_invalid();
    logic [15:0] vals [2] = '{16'h00A5, 16'h0005};
    logic        want [2] = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      int seen = -1;
      carga = 1'b1; dato = vals[v];
      for (int c = 0; c < FRAME + 4; c++) begin
        @(negedge clk);
        carga = 1'b0;
        n_checks++;
        if (obs1 !== exp_vec(1)) begin
          n_fail++; $display("FAIL invalid t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
        end
        if (listo1 && seen < 0) seen = c;
        if (seen >= 0 && c == seen + 1) begin
          n_checks++;
          if (invalido1 !== want[v]) begin
            n_fail++; $display("FAIL invalid_flag value=%h invalido=%b required=%b", vals[v], invalido1, want[v]);
          end
        end
      end
      n_checks++;
      if (seen < 0) begin
        n_fail++; $display("FAIL invalid_commit_timeout value=%h", vals[v]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL random t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
      n_checks++;
      if (obs2 !== exp_vec(0)) begin
        n_fail++; $display("FAIL random_nb t=%0d dut=%h model=%h", m_t, obs2, exp_vec(0));
      end
      d = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 0) d = d & ~(16'hF << (4 * i));
      end
      carga = ($urandom_range(0, 7) == 0);
      dato = d;
    end
    carga = 1'b0;
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    @(negedge clk);
    carga = 1'b1; dato = 16'h9876;
    @(negedge clk);
    carga = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs1 !== RESET_VEC) begin
      n_fail++; $display("FAIL async_reset dut=%h required=%h", obs1, RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2 * FRAME + 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs1 !== exp_vec(1) || nibble1 !== 4'h0) begin
        n_fail++; $display("FAIL after_reset t=%0d dut=%h model=%h", m_t, obs1, exp_vec(1));
      end
      if (listo1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL after_reset_listo pulses=%0d required=0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_blanking();
    test_back_to_back();
    test_invalid();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
